// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Holds the FSM state encoding and the slice width.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_cla_adder16_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
// Reused once per nibble by the serial adder.
module cla4_slice
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // every carry is flattened from g/p/cin, none ripples
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign s    = w_p ^ w_c[3:0];
  assign cout = w_c[4];

endmodule

// File: rtl/serial_cla_adder16.sv
// Nibble-serial adder: one CLA slice per cycle, valid/ready on both sides.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_cla_adder16
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_e r_state;
  state_e w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDX_W-1:0] r_idx;

  logic [NIBBLE_W-1:0] w_na;
  logic [NIBBLE_W-1:0] w_nb;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;
  logic                w_last;

  assign w_na   = NIBBLE_W'(r_a >> {r_idx, 2'b00});
  assign w_nb   = NIBBLE_W'(r_b >> {r_idx, 2'b00});
  assign w_last = (r_idx == LAST);

  cla4_slice u_slice (
    .a    (w_na),
    .b    (w_nb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  logic w_c_msb;

  // carry into the MSB recovered from the top bit's sum
  assign w_c_msb = w_na[3] ^ w_nb[3] ^ w_s[3];
  assign ovf     = r_ovf;

  always_ff @(posedge clk) begin
    if (rst)                       r_ovf <= 1'b0;
    else if (r_state == RUN && w_last) r_ovf <= w_c_msb ^ w_co;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: NIBBLE_W] <= w_s;
          r_carry <= w_co;
          r_idx   <= r_idx + IDX_W'(1);
          if (w_last) r_cout <= w_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cla_adder16.sv
// Directed and random bench for serial_cla_adder16 (WIDTH=16).
// Reference is plain a+b+cin arithmetic captured at acceptance.
module tb_serial_cla_adder16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
`ifdef SERIAL_ADD_OVF_EN
  logic        ovf;
`endif

  int tests = 0;
  int fails = 0;

  logic        exp_pend = 1'b0;
  logic [15:0] exp_sum  = '0;
  logic        exp_cout = 1'b0;
  logic        exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_cla_adder16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic model(input logic [15:0] ma, input logic [15:0] mb,
                       input logic mc);
    logic [16:0] t;
    t = {1'b0, ma} + {1'b0, mb} + 17'(mc);
    exp_sum  = t[15:0];
    exp_cout = t[16];
    exp_ovf  = (ma[15] == mb[15]) && (t[15] != ma[15]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("hs_excl", 32'(in_ready & out_valid), 32'd0);
      chk("spurious_ov", 32'(out_valid & ~exp_pend), 32'd0);
      if (out_valid && exp_pend) begin
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("cout", 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(exp_ovf));
`endif
      end
    end
  end

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input int stall, input bit lit,
                        input logic [15:0] lsum, input logic lcout,
                        input logic lovf);
    int n;
    logic [15:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    model(ta, tb_, tc);
    exp_pend = 1'b1;
    @(posedge clk); #1;
    a = ~ta; b = 16'($urandom); cin = ~tc;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'd4);
    if (lit) begin
      chk("lit_sum", 32'(sum), 32'(lsum));
      chk("lit_cout", 32'(cout), 32'(lcout));
      chk("model_pin", 32'({exp_cout, exp_sum}), 32'({lcout, lsum}));
`ifdef SERIAL_ADD_OVF_EN
      chk("lit_ovf", 32'(ovf), 32'(lovf));
`else
      if (lovf === 1'bx) $display("unused");
`endif
    end
    held = sum;
    for (int i = 0; i < stall; i++) begin
      in_valid = (i == 0);
      a = 16'hDEAD; b = 16'hBEEF;
      @(posedge clk); #1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_hold", 32'(sum), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_pend = 1'b0;
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'h1234, 16'h4321, 1'b0, 0, 1, 16'h5555, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1, 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1, 1, 16'h8000, 1'b0, 1'b1);
    run_op(16'h0F0F, 16'h00F1, 1'b1, 5, 1, 16'h1001, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1, 16'hFFFF, 1'b1, 1'b0);

    // abort in the RUN cycle that handles nibble 2
    a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_quiet", 32'(out_valid), 32'd0);

    for (int k = 0; k < 1000; k++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 0, 16'h0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
